// File: rtl/basepair_read_extractor.sv
// Extracts a READ_BASES-long window from a 2-bit-encoded reference starting at
// a base index, streaming bases over valid/ready and presenting the assembled read.
module basepair_read_extractor #(
    parameter int REF_BASES  = 50,
    parameter int READ_BASES = 10,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IDX_W-1:0]        index,
    input  logic [2*REF_BASES-1:0]  reference,
    output logic [1:0]              base_out,
    output logic                    base_valid,
    input  logic                    base_ready,
    output logic [2*READ_BASES-1:0] shortread_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(REF_BASES - READ_BASES);
    localparam logic [3:0]       LAST_CNT = 4'(READ_BASES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                   state;
    logic [2*REF_BASES-1:0]   ref_q;
    logic [IDX_W-1:0]         ptr;
    logic [3:0]               cnt;
    // Holds the first READ_BASES-1 bases; the final base joins straight from base_out.
    logic [2*READ_BASES-3:0]  shift;

    // Base 0 sits in the MSBs of the reference vector.
    function automatic logic [1:0] base_at(input logic [2*REF_BASES-1:0] r,
                                           input logic [IDX_W-1:0]       i);
        logic [1:0] res;
        res = '0;
        for (int unsigned b = 0; b < REF_BASES; b++) begin
            if (i == IDX_W'(b))
                res = 2'(r >> (2 * (REF_BASES - 1 - b)));
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ref_q         <= '0;
            ptr           <= '0;
            cnt           <= '0;
            shift         <= '0;
            base_out      <= '0;
            base_valid    <= 1'b0;
            shortread_out <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ref_q <= reference;
                        ptr   <= index;
                        if (index > MAX_IDX) begin
                            error <= 1'b1;
                        end else begin
                            cnt        <= '0;
                            shift      <= '0;
                            base_out   <= base_at(reference, index);
                            base_valid <= 1'b1;
                            busy       <= 1'b1;
                            state      <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (base_valid && base_ready) begin
                        shift <= {shift[2*READ_BASES-5:0], base_out};
                        ptr   <= ptr + IDX_W'(1);
                        cnt   <= cnt + 4'd1;
                        if (cnt == LAST_CNT) begin
                            shortread_out <= {shift, base_out};
                            base_valid    <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end else begin
                            base_out <= base_at(ref_q, ptr + IDX_W'(1));
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
